// File: rtl/data_mem_mailbox.sv
// Data memory for the single-cycle RV32I core, with a path mailbox that captures, hands off and scrubs.
// Optional macro DATA_MEM_MISALIGN_EN adds misaligned-access detection and the misalign_err port.
module data_mem_mailbox #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 64,
  parameter int unsigned DONE_WORD  = 3,
  parameter int unsigned PATH_BASE  = 52,
  parameter int unsigned PATH_MAX   = 16,
  parameter int unsigned LEN_WORD   = 59,
  parameter int unsigned LEN_BYTE   = 2
) (
  input  logic                        adc_sck,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [ADDR_WIDTH-1:0]       addr,
  input  logic [31:0]                 wr_data,
  input  logic [2:0]                  funct3,
  output logic [31:0]                 rd_data,
  input  logic [$clog2(PATH_MAX)-1:0] path_rd_idx,
  output logic [7:0]                  path_byte,
  output logic [7:0]                  path_len,
  output logic                        path_ovf,
  output logic                        path_valid,
  input  logic                        path_ack,
  output logic                        busy,
`ifdef DATA_MEM_MISALIGN_EN
  output logic                        misalign_err,
`endif
  output logic                        cpu_restart
);

  localparam int unsigned AW = $clog2(MEM_SIZE);
  localparam int unsigned IW = $clog2(PATH_MAX);
  localparam int unsigned BW = AW + 2;

  typedef enum logic [1:0] {S_RUN, S_CAPTURE, S_VALID, S_CLEAR} state_t;

  state_t        state;
  logic [31:0]   ram [MEM_SIZE];
  logic [7:0]    path_buf [PATH_MAX];
  logic [IW-1:0] k;
  logic [AW-1:0] c;

  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic [31:0]   word;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [3:0]    st_mask;
  logic [31:0]   st_data;
  logic [BW-1:0] cap_addr;
  logic [7:0]    cap_byte;
  logic [7:0]    len_byte;
  logic          ld_mis;
  logic          st_mis;
  logic          unused_addr;

  assign widx        = addr[AW+1:2];
  assign lane        = addr[1:0];
  assign unused_addr = ^addr[ADDR_WIDTH-1:AW+2];
  assign path_byte   = path_buf[path_rd_idx];

`ifdef DATA_MEM_MISALIGN_EN
  assign ld_mis = ((funct3 == 3'b001 || funct3 == 3'b101) && addr[0]) ||
                  (funct3 == 3'b010 && addr[1:0] != 2'b00);
  assign st_mis = (funct3[1:0] == 2'b01 && addr[0]) ||
                  (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  assign misalign_err = wr_en ? st_mis : ld_mis;
`else
  assign ld_mis = 1'b0;
  assign st_mis = 1'b0;
`endif

  // Load path: lane select then sign/zero extension
  always_comb begin
    word    = ram[widx];
    ld_byte = word[{lane, 3'b000} +: 8];
    ld_half = word[{lane[1], 4'b0000} +: 16];
    rd_data = '0;
    case (funct3)
      3'b000:  rd_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  rd_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  rd_data = word;
      3'b100:  rd_data = {24'd0, ld_byte};
      3'b101:  rd_data = {16'd0, ld_half};
      default: rd_data = '0;
    endcase
    if (ld_mis) rd_data = '0;
  end

  // Store path: byte-lane enables with replicated data
  always_comb begin
    st_mask = 4'b0000;
    st_data = '0;
    case (funct3[1:0])
      2'b00: begin
        st_mask = 4'b0001 << lane;
        st_data = {4{wr_data[7:0]}};
      end
      2'b01: begin
        st_mask = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wr_data[15:0]}};
      end
      2'b10: begin
        st_mask = 4'b1111;
        st_data = wr_data;
      end
      default: st_mask = 4'b0000;
    endcase
    if (!wr_en || st_mis) st_mask = 4'b0000;
  end

  always_comb begin
    cap_addr = BW'(PATH_BASE * 4) + BW'(k);
    cap_byte = ram[cap_addr[BW-1:2]][{cap_addr[1:0], 3'b000} +: 8];
    len_byte = ram[AW'(LEN_WORD)][LEN_BYTE*8 +: 8];
  end

  // RAM writes: CPU stores in RUN, one-word scrub in CLEAR
  always_ff @(posedge adc_sck) begin
    if (!reset) begin
      if (state == S_RUN) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (st_mask[b]) ram[widx][b*8 +: 8] <= st_data[b*8 +: 8];
        end
      end else if (state == S_CLEAR) begin
        ram[c] <= '0;
      end
    end
  end

  always_ff @(posedge adc_sck) begin
    if (reset) begin
      state       <= S_CLEAR;
      c           <= '0;
      k           <= '0;
      for (int unsigned i = 0; i < PATH_MAX; i++) path_buf[i] <= '0;
      path_len    <= '0;
      path_ovf    <= 1'b0;
      path_valid  <= 1'b0;
      busy        <= 1'b1;
      cpu_restart <= 1'b0;
    end else begin
      cpu_restart <= 1'b0;
      case (state)
        S_RUN: begin
          if (ram[AW'(DONE_WORD)] == 32'd1) begin
            state <= S_CAPTURE;
            k     <= '0;
            busy  <= 1'b1;
          end
        end
        S_CAPTURE: begin
          path_buf[k] <= cap_byte;
          k           <= k + IW'(1);
          if (k == IW'(PATH_MAX - 1)) begin
            state      <= S_VALID;
            path_len   <= (32'(len_byte) > PATH_MAX) ? 8'(PATH_MAX) : len_byte;
            path_ovf   <= 32'(len_byte) > PATH_MAX;
            path_valid <= 1'b1;
            busy       <= 1'b0;
          end
        end
        S_VALID: begin
          if (path_ack) begin
            state      <= S_CLEAR;
            c          <= '0;
            for (int unsigned i = 0; i < PATH_MAX; i++) path_buf[i] <= '0;
            path_len   <= '0;
            path_ovf   <= 1'b0;
            path_valid <= 1'b0;
            busy       <= 1'b1;
          end
        end
        default: begin
          c <= c + AW'(1);
          if (c == AW'(MEM_SIZE - 1)) begin
            state       <= S_RUN;
            busy        <= 1'b0;
            cpu_restart <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_mailbox.sv
// Directed bench for data_mem_mailbox; expected values queued on stimulus, popped on DUT output.
module tb_data_mem_mailbox;

  logic        adc_sck = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic [2:0]  funct3 = 3'b010;
  logic [31:0] rd_data;
  logic [3:0]  path_rd_idx = '0;
  logic [7:0]  path_byte;
  logic [7:0]  path_len;
  logic        path_ovf;
  logic        path_valid;
  logic        path_ack = 1'b0;
  logic        busy;
  logic        cpu_restart;
`ifdef DATA_MEM_MISALIGN_EN
  logic        misalign_err;
`endif

  data_mem_mailbox dut (
    .adc_sck     (adc_sck),
    .reset       (reset),
    .wr_en       (wr_en),
    .addr        (addr),
    .wr_data     (wr_data),
    .funct3      (funct3),
    .rd_data     (rd_data),
    .path_rd_idx (path_rd_idx),
    .path_byte   (path_byte),
    .path_len    (path_len),
    .path_ovf    (path_ovf),
    .path_valid  (path_valid),
    .path_ack    (path_ack),
    .busy        (busy),
`ifdef DATA_MEM_MISALIGN_EN
    .misalign_err(misalign_err),
`endif
    .cpu_restart (cpu_restart)
  );

  always #5 adc_sck = ~adc_sck;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic expect_val(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t x;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] f3, input string tag,
                    input logic [31:0] e);
    expect_val(tag, e);
    wr_en  = 1'b0;
    addr   = a;
    funct3 = f3;
    #1;
    check(rd_data);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    addr    = a;
    wr_data = d;
    funct3  = f3;
    wr_en   = 1'b1;
    @(posedge adc_sck);
    #1;
    wr_en = 1'b0;
  endtask

  // Counts cycles until busy drops, plus restart pulses and any path_valid seen on the way
  task automatic scrub_check(input string tag);
    int cyc;
    int pulses;
    int vseen;
    cyc = 0;
    pulses = 0;
    vseen = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge adc_sck);
      #1;
      if (cpu_restart) pulses++;
      if (path_valid) vseen++;
      if (!busy) begin
        cyc = n;
        break;
      end
    end
    repeat (3) begin
      @(posedge adc_sck);
      #1;
      if (cpu_restart) pulses++;
    end
    expect_val({tag, "_cycles"}, 32'd64);
    check(32'(cyc));
    expect_val({tag, "_restart_pulses"}, 32'd1);
    check(32'(pulses));
    expect_val({tag, "_valid_seen"}, 32'd0);
    check(32'(vseen));
  endtask

  task automatic load_path(input logic [31:0] len_word);
    st(32'hD0, 32'h04030201, 3'b010);
    st(32'hD4, 32'h08070605, 3'b010);
    st(32'hD8, 32'h0C0B0A09, 3'b010);
    st(32'hDC, 32'h100F0E0D, 3'b010);
    st(32'hEC, len_word, 3'b010);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!path_valid && n < 40) begin
      @(posedge adc_sck);
      #1;
      n++;
      if (n == 1) begin
        expect_val({tag, "_busy_capture"}, 32'd1);
        check(32'(busy));
        addr    = 32'hD0;
        wr_data = 32'hFFFFFFFF;
        funct3  = 3'b010;
        wr_en   = 1'b1;
      end else if (n == 2) begin
        wr_en = 1'b0;
      end
    end
    expect_val({tag, "_valid_latency"}, 32'd17);
    check(32'(n));
    expect_val({tag, "_busy_valid"}, 32'd0);
    check(32'(busy));
  endtask

  task automatic ack_path(input string tag);
    path_ack = 1'b1;
    @(posedge adc_sck);
    #1;
    path_ack = 1'b0;
    expect_val({tag, "_valid_after_ack"}, 32'd0);
    check(32'(path_valid));
    expect_val({tag, "_len_after_ack"}, 32'd0);
    check(32'(path_len));
    expect_val({tag, "_busy_after_ack"}, 32'd1);
    check(32'(busy));
    scrub_check(tag);
  endtask

  initial begin
    // 1: reset and initial scrub
    repeat (2) @(posedge adc_sck);
    #1;
    reset = 1'b0;
    expect_val("busy_after_reset", 32'd1);
    check(32'(busy));
    expect_val("valid_after_reset", 32'd0);
    check(32'(path_valid));
    scrub_check("init_scrub");
    ld(32'h0, 3'b010, "lw_zero_0", 32'h0);
    ld(32'hFC, 3'b010, "lw_zero_fc", 32'h0);
    ld(32'h1234, 3'b010, "lw_zero_wrap", 32'h0);

    // 2: sub-word stores and loads
    st(32'h10, 32'h8899AABB, 3'b010);
    st(32'h11, 32'h00000011, 3'b000);
    st(32'h12, 32'h00002233, 3'b001);
    ld(32'h10, 3'b010, "lw_merged", 32'h223311BB);
    ld(32'h11, 3'b000, "lb_11", 32'h00000011);
    ld(32'h12, 3'b001, "lh_12", 32'h00002233);
    ld(32'h10, 3'b100, "lbu_10", 32'h000000BB);
    ld(32'h10, 3'b000, "lb_10_sext", 32'hFFFFFFBB);
    ld(32'h110, 3'b010, "lw_addr_wrap", 32'h223311BB);
    ld(32'h10, 3'b011, "ld_bad_funct3", 32'h0);
    st(32'h14, 32'h0000F0F0, 3'b001);
    ld(32'h14, 3'b001, "lh_sext", 32'hFFFFF0F0);
    ld(32'h14, 3'b101, "lhu_zext", 32'h0000F0F0);
    path_ack = 1'b1;
    @(posedge adc_sck);
    #1;
    path_ack = 1'b0;
    expect_val("ack_in_run_ignored", 32'd0);
    check(32'(busy));

    // 3: path capture with length 13
    load_path(32'h000D0000);
    st(32'h0C, 32'd1, 3'b010);
    wait_valid("cap13");
    expect_val("cap13_len", 32'd13);
    check(32'(path_len));
    expect_val("cap13_ovf", 32'd0);
    check(32'(path_ovf));
    ld(32'hD0, 3'b010, "store_dropped_in_capture", 32'h04030201);
    for (int i = 0; i < 16; i++) begin
      path_rd_idx = 4'(i);
      expect_val("cap13_path_byte", 32'(i + 1));
      #1;
      check(32'(path_byte));
    end
    st(32'h20, 32'h12345678, 3'b010);
    ld(32'h20, 3'b010, "store_dropped_in_valid", 32'h0);
    ack_path("ack13");

    // 4: length overflow, ack, full scrub
    load_path(32'h00200000);
    st(32'h0C, 32'd1, 3'b010);
    wait_valid("cap32");
    expect_val("cap32_len_sat", 32'd16);
    check(32'(path_len));
    expect_val("cap32_ovf", 32'd1);
    check(32'(path_ovf));
    path_rd_idx = 4'd15;
    expect_val("cap32_last_byte", 32'h10);
    #1;
    check(32'(path_byte));
    ack_path("ack32");
    expect_val("path_byte_cleared", 32'h0);
    check(32'(path_byte));
    for (int i = 0; i < 64; i++) ld(32'(i * 4), 3'b010, "ram_scrubbed", 32'h0);

    // 5: reset in the middle of capture
    load_path(32'h000D0000);
    st(32'h0C, 32'd1, 3'b010);
    repeat (6) @(posedge adc_sck);
    #1;
    reset = 1'b1;
    @(posedge adc_sck);
    #1;
    reset = 1'b0;
    expect_val("midcap_reset_busy", 32'd1);
    check(32'(busy));
    expect_val("midcap_reset_valid", 32'd0);
    check(32'(path_valid));
    scrub_check("midcap_scrub");
    ld(32'h0C, 3'b010, "midcap_done_cleared", 32'h0);
    ld(32'hD0, 3'b010, "midcap_path_cleared", 32'h0);
    path_rd_idx = 4'd0;
    expect_val("midcap_buf_cleared", 32'h0);
    #1;
    check(32'(path_byte));

`ifdef DATA_MEM_MISALIGN_EN
    // 6: misaligned accesses
    st(32'h10, 32'h11223344, 3'b010);
    addr    = 32'h12;
    wr_data = 32'hFFFFFFFF;
    funct3  = 3'b010;
    wr_en   = 1'b1;
    expect_val("misalign_sw_err", 32'd1);
    #1;
    check(32'(misalign_err));
    @(posedge adc_sck);
    #1;
    wr_en = 1'b0;
    ld(32'h10, 3'b010, "misalign_sw_dropped", 32'h11223344);
    ld(32'h13, 3'b001, "misalign_lh_zero", 32'h0);
    expect_val("misalign_lh_err", 32'd1);
    check(32'(misalign_err));
    ld(32'h12, 3'b001, "aligned_lh", 32'h00001122);
    expect_val("aligned_lh_err", 32'd0);
    check(32'(misalign_err));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
